ysyx_22041207_hazard_ctrl: RTL

//  Central pipeline controller for the 5-stage core. Generates the stall, bubble (hold) and flush

---
 rtl/ysyx_22041207_hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush generation for the 5-stage core.
// Control outputs are combinational from the current state and inputs so the
// negedge-sampled pipeline registers see them within the same cycle.
module ysyx_22041207_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_MAX = 64,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_bubble,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mdu_timeout
);

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_MDU = 2'd1;
    localparam logic [1:0] ST_MEM = 2'd2;

    localparam int              MC_W      = $clog2(MDU_MAX + 1);
    localparam logic [MC_W-1:0] MDU_MAX_C = MC_W'(MDU_MAX);

    // Packed control vector: {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble,
    //                         id_ex_flush, ex_mem_bubble, ex_mem_flush}
    localparam logic [6:0] CTL_NONE   = 7'b000_0000;
    localparam logic [6:0] CTL_FREEZE = 7'b110_1010;
    localparam logic [6:0] CTL_REDIR  = 7'b001_0100;
    localparam logic [6:0] CTL_MDU    = 7'b110_1001;
    localparam logic [6:0] CTL_LUH    = 7'b110_0100;

    logic [1:0]       state_q, state_d, eff_state_s;
    logic             redirect_pend_q, redirect_pend_d;
    logic             ret_mdu_q, ret_mdu_d;
    logic [MC_W-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mdu_timeout_q, mdu_timeout_d;
    logic [6:0]       ctl_s;
    logic             luh_s;

    // Load-use hazard: the EX load writes a register the ID instruction reads.
    always_comb begin
        luh_s = ex_is_load && (ex_rd != {REG_W{1'b0}}) &&
                ((id_rs1_ren && (id_rs1 == ex_rd)) || (id_rs2_ren && (id_rs2 == ex_rd)));
    end

    // Next-state and control decode; a MEM state whose wait just ended behaves
    // as the state it returns to, so that state's rules apply in the same cycle.
    always_comb begin
        ctl_s           = CTL_NONE;
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        ret_mdu_d       = ret_mdu_q;
        mdu_cnt_d       = mdu_cnt_q;
        mdu_timeout_d   = mdu_timeout_q;

        if ((state_q == ST_MEM) && !mem_busy) begin
            eff_state_s = ret_mdu_q ? ST_MDU : ST_RUN;
        end else begin
            eff_state_s = state_q;
        end

        case (eff_state_s)
            ST_RUN: begin
                if (mem_busy) begin
                    ctl_s           = CTL_FREEZE;
                    state_d         = ST_MEM;
                    ret_mdu_d       = 1'b0;
                    redirect_pend_d = redirect_pend_q | ex_redirect;
                end else if (ex_redirect || redirect_pend_q) begin
                    ctl_s           = CTL_REDIR;
                    state_d         = ST_RUN;
                    redirect_pend_d = 1'b0;
                end else if (ex_mdu_start && !mdu_done) begin
                    ctl_s     = CTL_MDU;
                    state_d   = ST_MDU;
                    mdu_cnt_d = MC_W'(1);
                end else if (luh_s) begin
                    ctl_s   = CTL_LUH;
                    state_d = ST_RUN;
                end else begin
                    ctl_s   = CTL_NONE;
                    state_d = ST_RUN;
                end
            end
            ST_MDU: begin
                redirect_pend_d = redirect_pend_q | ex_redirect;
                if (mem_busy) begin
                    ctl_s     = CTL_FREEZE;
                    state_d   = ST_MEM;
                    ret_mdu_d = 1'b1;
                end else if (mdu_done) begin
                    ctl_s   = CTL_NONE;
                    state_d = ST_RUN;
                end else if (mdu_cnt_q == MDU_MAX_C) begin
                    ctl_s         = CTL_NONE;
                    state_d       = ST_RUN;
                    mdu_timeout_d = 1'b1;
                end else begin
                    ctl_s     = CTL_MDU;
                    state_d   = ST_MDU;
                    mdu_cnt_d = mdu_cnt_q + MC_W'(1);
                end
            end
            ST_MEM: begin
                ctl_s           = CTL_FREEZE;
                state_d         = ST_MEM;
                redirect_pend_d = redirect_pend_q | ex_redirect;
            end
            default: begin
                ctl_s   = CTL_NONE;
                state_d = ST_RUN;
            end
        endcase

        if (ctl_s[6] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            redirect_pend_q <= 1'b0;
            ret_mdu_q       <= 1'b0;
            mdu_cnt_q       <= {MC_W{1'b0}};
            stall_cnt_q     <= {CNT_W{1'b0}};
            mdu_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            ret_mdu_q       <= ret_mdu_d;
            mdu_cnt_q       <= mdu_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            mdu_timeout_q   <= mdu_timeout_d;
        end
    end

    // Output drive; control lines are held low throughout reset.
    always_comb begin
        if (rst) begin
            {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble,
             id_ex_flush, ex_mem_bubble, ex_mem_flush} = CTL_NONE;
        end else begin
            {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble,
             id_ex_flush, ex_mem_bubble, ex_mem_flush} = ctl_s;
        end
        ctrl_state  = state_q;
        stall_cnt   = stall_cnt_q;
        mdu_timeout = mdu_timeout_q;
    end

endmodule
